// File: rtl/stage_mem_pkg.sv
// ============================================================================
// Module   : stage_mem_pkg
// Brief    : Shared types and helpers for the handshaked memory stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stage_mem_pkg;

    localparam int MAX_LANES = 8;

    typedef enum logic [1:0] {
        ACCESS_BYTE   = 2'b00,
        ACCESS_HALF   = 2'b01,
        ACCESS_WORD   = 2'b10,
        ACCESS_DOUBLE = 2'b11
    } DataAccess;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_BUS      = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } MemFault;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_ZERO = 2'b11
    } RegWrSel;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RSP  = 2'b10
    } StageState;

    function automatic logic [MAX_LANES-1:0] size_mask(input DataAccess access);
        case (access)
            ACCESS_BYTE: size_mask = 8'h01;
            ACCESS_HALF: size_mask = 8'h03;
            ACCESS_WORD: size_mask = 8'h0F;
            default:     size_mask = 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_mem_hs_load_align.sv
// ============================================================================
// Module   : load_align
// Brief    : Extracts a load from its byte lane and sign/zero extends it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_align
    import stage_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             i_rdData,
    input  logic [$clog2(XLEN/8)-1:0]   i_offset,
    input  DataAccess                   i_access,
    input  logic                        i_isUnsigned,
    output logic [XLEN-1:0]             o_loadData
);

    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_keep;
    logic            w_sign;

    always_comb begin
        w_shifted = i_rdData >> {i_offset, 3'b000};
        case (i_access)
            ACCESS_BYTE: begin
                w_keep = XLEN'(8'hFF);
                w_sign = w_shifted[7];
            end
            ACCESS_HALF: begin
                w_keep = XLEN'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            ACCESS_WORD: begin
                w_keep = XLEN'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: begin
                w_keep = '1;
                w_sign = w_shifted[XLEN-1];
            end
        endcase
        o_loadData = (w_shifted & w_keep) | (~w_keep & {XLEN{w_sign & ~i_isUnsigned}});
    end

endmodule

`default_nettype wire

// File: rtl/stage_mem_hs.sv
// ============================================================================
// Module   : stage_mem_hs
// Brief    : Memory pipeline stage with request/grant/response bus and stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_mem_hs
    import stage_mem_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int PC_INC     = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [PC_WIDTH-1:0]     i_pc,
    input  logic [XLEN-1:0]         i_result,
    input  logic [XLEN-1:0]         i_dataB,
    input  logic                    i_memWrEnable,
    input  logic                    i_memRdEnable,
    input  logic [1:0]              i_memAccess,
    input  logic                    i_memUnsigned,
    input  logic [1:0]              i_regWrDataSel,
    output logic                    o_valid,
    output logic [XLEN-1:0]         o_regWrData,
    output logic [1:0]              o_fault,
    output logic [ADDR_WIDTH-1:0]   o_faultAddr,
    output logic                    o_busReq,
    input  logic                    i_busGnt,
    output logic [ADDR_WIDTH-1:0]   o_busAddr,
    output logic                    o_busWrite,
    output logic [XLEN/8-1:0]       o_busByteEn,
    output logic [XLEN-1:0]         o_busWrData,
    input  logic                    i_busRspValid,
    input  logic [XLEN-1:0]         i_busRdData,
    input  logic                    i_busError
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int TOW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    StageState              r_state;
    logic                   r_busReq;
    logic [ADDR_WIDTH-1:0]  r_busAddr;
    logic                   r_busWrite;
    logic [LANES-1:0]       r_busByteEn;
    logic [XLEN-1:0]        r_busWrData;
    logic                   r_valid;
    logic [XLEN-1:0]        r_regWrData;
    MemFault                r_fault;
    logic [ADDR_WIDTH-1:0]  r_faultAddr;
    logic [TOW-1:0]         r_toCnt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    DataAccess              r_access;
    logic                   r_unsigned;
    RegWrSel                r_sel;
    logic [XLEN-1:0]        r_alu;
    logic [XLEN-1:0]        r_link;

    DataAccess              w_access;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [OFFW-1:0]        w_off;
    logic [2:0]             w_alignMask;
    logic                   w_misaligned;
    logic                   w_isMem;
    logic [LANES-1:0]       w_laneMask;
    logic [LANES-1:0]       w_byteEn;
    logic [XLEN-1:0]        w_wrData;
    logic [PC_WIDTH-1:0]    w_linkPc;
    logic [XLEN-1:0]        w_loadData;
    logic [TOW-1:0]         w_toNext;
    logic                   w_rspTaken;
    logic                   w_timedOut;
    MemFault                w_cmplFault;

    assign w_access    = DataAccess'(i_memAccess);
    assign w_addr      = i_result[ADDR_WIDTH-1:0];
    assign w_off       = w_addr[OFFW-1:0];
    assign w_isMem     = i_memWrEnable | i_memRdEnable;
    assign w_alignMask = {w_access == ACCESS_DOUBLE,
                          (w_access == ACCESS_WORD) || (w_access == ACCESS_DOUBLE),
                          w_access != ACCESS_BYTE};
    // A double access has no legal alignment on a 32-bit datapath.
    assign w_misaligned = (|(w_addr[2:0] & w_alignMask)) ||
                          ((w_access == ACCESS_DOUBLE) && (XLEN < 64));
    assign w_laneMask  = LANES'(size_mask(w_access));
    assign w_byteEn    = w_laneMask << w_off;
    assign w_wrData    = i_dataB << {w_off, 3'b000};
    assign w_linkPc    = i_pc + PC_WIDTH'(PC_INC);

    load_align #(
        .XLEN (XLEN)
    ) u_loadAlign (
        .i_rdData     (i_busRdData),
        .i_offset     (r_addr[OFFW-1:0]),
        .i_access     (r_access),
        .i_isUnsigned (r_unsigned),
        .o_loadData   (w_loadData)
    );

    // A response is honoured in REQ only when it coincides with the grant.
    assign w_rspTaken  = i_busRspValid &&
                         (((r_state == ST_REQ) && i_busGnt) || (r_state == ST_RSP));
    assign w_toNext    = r_toCnt + TOW'(1);
    assign w_timedOut  = (TIMEOUT != 0) && (r_state == ST_RSP) && !i_busRspValid &&
                         (w_toNext == TOW'(TIMEOUT));
    assign w_cmplFault = w_timedOut ? FAULT_TIMEOUT : (i_busError ? FAULT_BUS : FAULT_NONE);

    function automatic logic [XLEN-1:0] wbValue(
        input RegWrSel         sel,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] link,
        input logic [XLEN-1:0] load,
        input logic            loadOk
    );
        case (sel)
            SEL_ALU:  wbValue = alu;
            SEL_LOAD: wbValue = loadOk ? load : '0;
            SEL_LINK: wbValue = link;
            default:  wbValue = '0;
        endcase
    endfunction

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_busReq    <= 1'b0;
            r_busAddr   <= '0;
            r_busWrite  <= 1'b0;
            r_busByteEn <= '0;
            r_busWrData <= '0;
            r_valid     <= 1'b0;
            r_regWrData <= '0;
            r_fault     <= FAULT_NONE;
            r_faultAddr <= '0;
            r_toCnt     <= '0;
            r_addr      <= '0;
            r_access    <= ACCESS_BYTE;
            r_unsigned  <= 1'b0;
            r_sel       <= SEL_ALU;
            r_alu       <= '0;
            r_link      <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_rspTaken || w_timedOut) begin
                r_valid     <= 1'b1;
                r_fault     <= w_cmplFault;
                r_faultAddr <= (w_cmplFault != FAULT_NONE) ? r_addr : '0;
                r_regWrData <= wbValue(r_sel, r_alu, r_link, w_loadData,
                                       w_cmplFault == FAULT_NONE);
                r_busReq    <= 1'b0;
                r_busByteEn <= '0;
                r_state     <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_valid) begin
                            r_addr     <= w_addr;
                            r_access   <= w_access;
                            r_unsigned <= i_memUnsigned;
                            r_sel      <= RegWrSel'(i_regWrDataSel);
                            r_alu      <= i_result;
                            r_link     <= XLEN'(w_linkPc);
                            if (!w_isMem) begin
                                r_valid     <= 1'b1;
                                r_fault     <= FAULT_NONE;
                                r_faultAddr <= '0;
                                r_regWrData <= wbValue(RegWrSel'(i_regWrDataSel), i_result,
                                                       XLEN'(w_linkPc), '0, 1'b0);
                            end else if (w_misaligned) begin
                                r_valid     <= 1'b1;
                                r_fault     <= FAULT_MISALIGN;
                                r_faultAddr <= w_addr;
                                r_regWrData <= '0;
                            end else begin
                                r_busReq    <= 1'b1;
                                r_busAddr   <= {w_addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
                                r_busWrite  <= i_memWrEnable;
                                r_busByteEn <= w_byteEn;
                                r_busWrData <= w_wrData;
                                r_state     <= ST_REQ;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (i_busGnt) begin
                            r_busReq    <= 1'b0;
                            r_busByteEn <= '0;
                            r_toCnt     <= '0;
                            r_state     <= ST_RSP;
                        end
                    end
                    ST_RSP: begin
                        r_toCnt <= w_toNext;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ready     = (r_state == ST_IDLE);
    assign o_valid     = r_valid;
    assign o_regWrData = r_regWrData;
    assign o_fault     = r_fault;
    assign o_faultAddr = r_faultAddr;
    assign o_busReq    = r_busReq;
    assign o_busAddr   = r_busAddr;
    assign o_busWrite  = r_busWrite;
    assign o_busByteEn = r_busByteEn;
    assign o_busWrData = r_busWrData;

endmodule

`default_nettype wire

// File: tb/tb_stage_mem_hs.sv
// ============================================================================
// Module   : tb_stage_mem_hs
// Brief    : Scoreboard bench for stage_mem_hs at XLEN=32 and XLEN=64.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stage_mem_hs;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    // XLEN=32 instance, TIMEOUT=4
    logic        valid, ready, wr, rd, uns;
    logic [31:0] pc, result, dataB;
    logic [1:0]  acc, sel;
    logic        oValid, busReq, gnt, busWrite, rspValid, busErr;
    logic [31:0] wbData, faultAddr, busAddr, busWrData, rdData;
    logic [1:0]  fault;
    logic [3:0]  byteEn;

    // XLEN=64 instance
    logic        v64, rdy64, wr64, rd64, uns64;
    logic [31:0] pc64;
    logic [63:0] res64, db64;
    logic [1:0]  acc64, sel64;
    logic        oV64, br64, gnt64, bw64, rsp64, err64;
    logic [63:0] wb64, bwd64, rdd64;
    logic [31:0] fa64, ba64;
    logic [1:0]  f64;
    logic [7:0]  be64;

    stage_mem_hs #(.XLEN(32), .ADDR_WIDTH(32), .PC_WIDTH(32), .PC_INC(4), .TIMEOUT(4)) dut (
        .i_clock(clk), .i_reset(rstN), .i_valid(valid), .o_ready(ready),
        .i_pc(pc), .i_result(result), .i_dataB(dataB),
        .i_memWrEnable(wr), .i_memRdEnable(rd), .i_memAccess(acc),
        .i_memUnsigned(uns), .i_regWrDataSel(sel),
        .o_valid(oValid), .o_regWrData(wbData), .o_fault(fault), .o_faultAddr(faultAddr),
        .o_busReq(busReq), .i_busGnt(gnt), .o_busAddr(busAddr), .o_busWrite(busWrite),
        .o_busByteEn(byteEn), .o_busWrData(busWrData),
        .i_busRspValid(rspValid), .i_busRdData(rdData), .i_busError(busErr)
    );

    stage_mem_hs #(.XLEN(64), .ADDR_WIDTH(32), .PC_WIDTH(32), .PC_INC(4), .TIMEOUT(255)) dut64 (
        .i_clock(clk), .i_reset(rstN), .i_valid(v64), .o_ready(rdy64),
        .i_pc(pc64), .i_result(res64), .i_dataB(db64),
        .i_memWrEnable(wr64), .i_memRdEnable(rd64), .i_memAccess(acc64),
        .i_memUnsigned(uns64), .i_regWrDataSel(sel64),
        .o_valid(oV64), .o_regWrData(wb64), .o_fault(f64), .o_faultAddr(fa64),
        .o_busReq(br64), .i_busGnt(gnt64), .o_busAddr(ba64), .o_busWrite(bw64),
        .o_busByteEn(be64), .o_busWrData(bwd64),
        .i_busRspValid(rsp64), .i_busRdData(rdd64), .i_busError(err64)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  fault;
        logic [63:0] addr;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp32(input logic [63:0] d, input logic [1:0] f, input logic [63:0] a);
        exp_t e;
        e.data = d; e.fault = f; e.addr = a;
        q32.push_back(e);
    endtask

    task automatic exp64(input logic [63:0] d, input logic [1:0] f, input logic [63:0] a);
        exp_t e;
        e.data = d; e.fault = f; e.addr = a;
        q64.push_back(e);
    endtask

    // Monitors: every result pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (rstN && oValid) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid32: got o_valid=1 expected no result");
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("wbData32", 64'(wbData), e.data);
                check("fault32", 64'(fault), 64'(e.fault));
                if (e.fault != 2'b00) check("faultAddr32", 64'(faultAddr), e.addr);
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && oV64) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid64: got o_valid=1 expected no result");
            end else begin
                exp_t e;
                e = q64.pop_front();
                check("wbData64", wb64, e.data);
                check("fault64", 64'(f64), 64'(e.fault));
                if (e.fault != 2'b00) check("faultAddr64", 64'(fa64), e.addr);
            end
        end
    end

    task automatic drive32(input logic [31:0] p, input logic [31:0] r, input logic [31:0] d,
                           input logic w, input logic rdE, input logic [1:0] a,
                           input logic u, input logic [1:0] s);
        @(negedge clk);
        check("ready_before_issue", 64'(ready), 64'd1);
        pc = p; result = r; dataB = d; wr = w; rd = rdE; acc = a; uns = u; sel = s;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic drive64(input logic [63:0] r, input logic [63:0] d, input logic w,
                           input logic rdE, input logic [1:0] a, input logic [1:0] s);
        @(negedge clk);
        res64 = r; db64 = d; wr64 = w; rd64 = rdE; acc64 = a; uns64 = 1'b0; sel64 = s;
        v64 = 1'b1;
        @(negedge clk);
        v64 = 1'b0; wr64 = 1'b0; rd64 = 1'b0;
    endtask

    task automatic busTxn32(input int gntDelay, input int rspDelay,
                            input logic [31:0] data, input logic e);
        for (int i = 0; i < gntDelay; i++) begin
            check("busReq_held", 64'(busReq), 64'd1);
            check("ready_low_req", 64'(ready), 64'd0);
            @(negedge clk);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        for (int i = 0; i < rspDelay; i++) begin
            check("ready_low_rsp", 64'(ready), 64'd0);
            @(negedge clk);
        end
        rspValid = 1'b1; rdData = data; busErr = e;
        @(negedge clk);
        rspValid = 1'b0; busErr = 1'b0; rdData = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int k;
        rstN = 1'b0;
        valid = 0; pc = 0; result = 0; dataB = 0; wr = 0; rd = 0; acc = 0; uns = 0; sel = 0;
        gnt = 0; rspValid = 0; rdData = 0; busErr = 0;
        v64 = 0; pc64 = 0; res64 = 0; db64 = 0; wr64 = 0; rd64 = 0; acc64 = 0; uns64 = 0;
        sel64 = 0; gnt64 = 0; rsp64 = 0; rdd64 = 0; err64 = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(oValid), 64'd0);
        check("rst_busReq", 64'(busReq), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_wbData", 64'(wbData), 64'd0);
        check("rst_faultAddr", 64'(faultAddr), 64'd0);
        check("rst_byteEn", 64'(byteEn), 64'd0);
        check("rst_busReq64", 64'(br64), 64'd0);
        rstN = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(ready), 64'd1);

        // ALU op, no stall
        exp32(64'h1234, 2'b00, 0);
        drive32(32'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
        check("alu_ready_high", 64'(ready), 64'd1);

        // Signed byte load at 0x1003
        exp32(64'hFFFF_FF80, 2'b00, 0);
        drive32(32'h0, 32'h1003, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01);
        check("lb_busAddr", 64'(busAddr), 64'h1000);
        check("lb_busWrite", 64'(busWrite), 64'd0);
        check("lb_byteEn", 64'(byteEn), 64'b1000);
        busTxn32(2, 2, 32'h80FF_FFFF, 1'b0);

        // Unsigned byte load
        exp32(64'h0000_0080, 2'b00, 0);
        drive32(32'h0, 32'h1003, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01);
        busTxn32(1, 0, 32'h80FF_FFFF, 1'b0);

        // Half store at 0x2002
        exp32(64'h2002, 2'b00, 0);
        drive32(32'h0, 32'h2002, 32'hABCD, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
        check("sh_byteEn", 64'(byteEn), 64'b1100);
        check("sh_wrData", 64'(busWrData), 64'hABCD_0000);
        check("sh_busWrite", 64'(busWrite), 64'd1);
        check("sh_busAddr", 64'(busAddr), 64'h2000);
        busTxn32(0, 1, 32'h0, 1'b0);

        // Signed half load from upper lanes
        exp32(64'hFFFF_8001, 2'b00, 0);
        drive32(32'h0, 32'h0000_0002, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01);
        busTxn32(0, 0, 32'h8001_0000, 1'b0);

        // Misaligned word load
        exp32(64'h0, 2'b01, 64'h1001);
        drive32(32'h0, 32'h1001, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01);
        check("mis_no_busReq", 64'(busReq), 64'd0);
        check("mis_ready", 64'(ready), 64'd1);

        // Double access on 32-bit datapath
        exp32(64'h0, 2'b01, 64'h8);
        drive32(32'h0, 32'h8, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b01);
        check("dbl32_no_busReq", 64'(busReq), 64'd0);

        // Bus error
        exp32(64'h0, 2'b10, 64'h3000);
        drive32(32'h0, 32'h3000, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01);
        busTxn32(0, 0, 32'h1234_5678, 1'b1);

        // Timeout after 4 RSP cycles, then a stray response
        exp32(64'h0, 2'b11, 64'h4000);
        drive32(32'h0, 32'h4000, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        k = 0;
        while (k < 10 && !oValid) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", 64'(k), 64'd4);
        rspValid = 1'b1; rdData = 32'hFFFF_FFFF;
        @(negedge clk);
        rspValid = 1'b0;
        repeat (2) @(negedge clk);
        exp32(64'h55, 2'b00, 0);
        drive32(32'h0, 32'h55, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);

        // Link values and zero select
        exp32(64'h0, 2'b00, 0);
        drive32(32'hFFFF_FFFC, 32'h9999, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10);
        exp32(64'h104, 2'b00, 0);
        drive32(32'h0000_0100, 32'h9999, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b10);
        exp32(64'h0, 2'b00, 0);
        drive32(32'h0, 32'hDEAD, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b11);

        // Reset during REQ
        drive32(32'h0, 32'h5000, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01);
        check("req_busReq_before_rst", 64'(busReq), 64'd1);
        #2 rstN = 1'b0;
        #1 check("rst_req_busReq", 64'(busReq), 64'd0);
        check("rst_req_ready", 64'(ready), 64'd1);
        @(negedge clk);
        rstN = 1'b1;

        // Reset during RSP
        drive32(32'h0, 32'h6000, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        @(negedge clk);
        #2 rstN = 1'b0;
        #1 check("rst_rsp_busReq", 64'(busReq), 64'd0);
        check("rst_rsp_valid", 64'(oValid), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        rspValid = 1'b1; rdData = 32'h1111_1111;
        @(negedge clk);
        rspValid = 1'b0;
        repeat (3) @(negedge clk);
        exp32(64'h77, 2'b00, 0);
        drive32(32'h0, 32'h77, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);

        // XLEN=64: double store, grant and response in the same cycle
        exp64(64'h8, 2'b00, 0);
        drive64(64'h8, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 2'b11, 2'b00);
        check("d64_byteEn", 64'(be64), 64'hFF);
        check("d64_busAddr", 64'(ba64), 64'h8);
        check("d64_wrData", bwd64, 64'h1122_3344_5566_7788);
        gnt64 = 1'b1; rsp64 = 1'b1;
        @(negedge clk);
        gnt64 = 1'b0; rsp64 = 1'b0;

        // XLEN=64: signed word load from upper half
        exp64(64'hFFFF_FFFF_8000_0000, 2'b00, 0);
        drive64(64'hC, 64'h0, 1'b0, 1'b1, 2'b10, 2'b01);
        check("w64_byteEn", 64'(be64), 64'hF0);
        gnt64 = 1'b1; rsp64 = 1'b1; rdd64 = 64'h8000_0000_0000_0000;
        @(negedge clk);
        gnt64 = 1'b0; rsp64 = 1'b0;

        // XLEN=64: misaligned double
        exp64(64'h0, 2'b01, 64'h4);
        drive64(64'h4, 64'h0, 1'b0, 1'b1, 2'b11, 2'b01);
        check("mis64_no_busReq", 64'(br64), 64'd0);

        repeat (3) @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q64_drained", 64'(q64.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
